// File: rtl/color_pkg.sv
// Shared definitions for the colour classifier.
//   DEF_WIDTH      : default bits per colour channel
//   CH_R/CH_G/CH_B : channel slot inside a packed {R,G,B} word
//   RST_LO_BIT/RST_HI_BIT : fill bits for the reset window (lo=all-ones, hi=0),
//                    which makes every class unmatched until it is programmed
package color_pkg;
  localparam int DEF_WIDTH = 8;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  localparam logic RST_LO_BIT = 1'b1;
  localparam logic RST_HI_BIT = 1'b0;
endpackage

// File: rtl/color_range_match.sv
// Three-channel inclusive window test for one class.
// Ports:
//   sample : packed {R,G,B} sample
//   lo, hi : packed {R,G,B} window bounds
//   match  : 1 when lo <= sample <= hi (unsigned) on all three channels
module color_range_match
  import color_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [3*WIDTH-1:0] sample,
  input  logic [3*WIDTH-1:0] lo,
  input  logic [3*WIDTH-1:0] hi,
  output logic               match
);

  function automatic logic in_win(input logic [WIDTH-1:0] s,
                                  input logic [WIDTH-1:0] l,
                                  input logic [WIDTH-1:0] h);
    return (s >= l) && (s <= h);
  endfunction

  always_comb begin
    match = in_win(sample[CH_R*WIDTH +: WIDTH], lo[CH_R*WIDTH +: WIDTH], hi[CH_R*WIDTH +: WIDTH])
         && in_win(sample[CH_G*WIDTH +: WIDTH], lo[CH_G*WIDTH +: WIDTH], hi[CH_G*WIDTH +: WIDTH])
         && in_win(sample[CH_B*WIDTH +: WIDTH], lo[CH_B*WIDTH +: WIDTH], hi[CH_B*WIDTH +: WIDTH]);
  end

endmodule

// File: rtl/color_classifier.sv
// Programmable colour window classifier with debounce.
// Two pipeline stages: S1 registers the per-class match vector, S2 registers
// the priority-encoded result and the debounce state.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   r/g/b_signal            : sample channels
//   in_valid / in_ready     : sample handshake
//   cfg_we/cfg_idx/cfg_lo/cfg_hi : window write port (bounds packed {R,G,B})
//   out_valid / out_ready   : result handshake
//   class_onehot            : every matching window
//   class_id / class_hit    : lowest matching index / any match
//   stable                  : same hit class seen HOLD consecutive results
// Optional macro CLASSIFIER_HIST_EN adds per-class hit counters:
//   hist_idx, hist_clr (in), hist_count (out, combinational read)
module color_classifier
  import color_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_CLASSES = 5,
  parameter int HOLD        = 4,
  localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       r_signal,
  input  logic [WIDTH-1:0]       g_signal,
  input  logic [WIDTH-1:0]       b_signal,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [3*WIDTH-1:0]     cfg_lo,
  input  logic [3*WIDTH-1:0]     cfg_hi,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CLASSES-1:0] class_onehot,
  output logic [IDX_W-1:0]       class_id,
  output logic                   class_hit,
  output logic                   stable
`ifdef CLASSIFIER_HIST_EN
  ,
  input  logic [IDX_W-1:0]       hist_idx,
  output logic [15:0]            hist_count,
  input  logic                   hist_clr
`endif
);

  localparam int CNT_W = $clog2(HOLD + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(HOLD)) ? c : c + 1'b1;
  endfunction

  logic                 adv;
  logic [3*WIDTH-1:0]   sample_p0;
  logic [3*WIDTH-1:0]   win_lo [NUM_CLASSES];
  logic [3*WIDTH-1:0]   win_hi [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] match_p0;

  logic                   vld_p1;
  logic [NUM_CLASSES-1:0] match_p1;
  logic [IDX_W-1:0]       id_p1;
  logic                   hit_p1;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   stable_nxt;
  logic [CNT_W-1:0]       cnt_p2;

  // Both stages move together; a stalled result freezes the whole pipe.
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;

  always_comb begin
    sample_p0 = '0;
    sample_p0[CH_R*WIDTH +: WIDTH] = r_signal;
    sample_p0[CH_G*WIDTH +: WIDTH] = g_signal;
    sample_p0[CH_B*WIDTH +: WIDTH] = b_signal;
  end

  // Window writes land on the clock edge, so a sample accepted in the same
  // cycle still sees the old bounds.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        win_lo[i] <= {(3*WIDTH){RST_LO_BIT}};
        win_hi[i] <= {(3*WIDTH){RST_HI_BIT}};
      end
    end else if (cfg_we && (int'(cfg_idx) < NUM_CLASSES)) begin
      win_lo[cfg_idx] <= cfg_lo;
      win_hi[cfg_idx] <= cfg_hi;
    end
  end

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_match
    color_range_match #(.WIDTH(WIDTH)) u_match (
      .sample (sample_p0),
      .lo     (win_lo[i]),
      .hi     (win_hi[i]),
      .match  (match_p0[i])
    );
  end

  // ---- S1: per-class match vector ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      match_p1 <= match_p0;
    end
  end

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    id_p1  = '0;
    hit_p1 = |match_p1;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (match_p1[i]) id_p1 = IDX_W'(i);
    end
  end

  // The S2 outputs only ever hold the last valid result, so they double as
  // the "previous result" for the debounce comparison. After reset the
  // counter is 0, so incrementing and loading 1 coincide.
  always_comb begin
    if ((id_p1 == class_id) && (hit_p1 == class_hit)) begin
      cnt_nxt = sat_inc(cnt_p2);
    end else begin
      cnt_nxt = CNT_W'(1);
    end
    stable_nxt = hit_p1 && (cnt_nxt == CNT_W'(HOLD));
  end

  // ---- S2: priority encode + debounce ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      class_onehot <= '0;
      class_id     <= '0;
      class_hit    <= 1'b0;
      stable       <= 1'b0;
      cnt_p2       <= '0;
    end else if (adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        class_onehot <= match_p1;
        class_id     <= id_p1;
        class_hit    <= hit_p1;
        stable       <= stable_nxt;
        cnt_p2       <= cnt_nxt;
      end
    end
  end

`ifdef CLASSIFIER_HIST_EN
  logic [15:0] hist [NUM_CLASSES];

  always_ff @(posedge clk) begin
    if (reset || hist_clr) begin
      for (int i = 0; i < NUM_CLASSES; i++) hist[i] <= '0;
    end else if (out_valid && out_ready && class_hit) begin
      if (hist[class_id] != 16'hFFFF) hist[class_id] <= hist[class_id] + 16'd1;
    end
  end

  assign hist_count = (int'(hist_idx) < NUM_CLASSES) ? hist[hist_idx] : 16'd0;
`endif

endmodule

// File: tb/tb_color_classifier.sv
module tb_color_classifier;
  import color_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  r_signal, g_signal, b_signal;
  logic        in_valid, in_ready;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [23:0] cfg_lo, cfg_hi;
  logic        out_valid, out_ready;
  logic [4:0]  class_onehot;
  logic [2:0]  class_id;
  logic        class_hit, stable;
`ifdef CLASSIFIER_HIST_EN
  logic [2:0]  hist_idx;
  logic [15:0] hist_count;
  logic        hist_clr;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] sb [$];
  bit sb_off = 1'b0;

  always #5 clk = ~clk;

  color_classifier #(.WIDTH(8), .NUM_CLASSES(5), .HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .r_signal(r_signal), .g_signal(g_signal), .b_signal(b_signal),
    .in_valid(in_valid), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .out_valid(out_valid), .out_ready(out_ready),
    .class_onehot(class_onehot), .class_id(class_id),
    .class_hit(class_hit), .stable(stable)
`ifdef CLASSIFIER_HIST_EN
    , .hist_idx(hist_idx), .hist_count(hist_count), .hist_clr(hist_clr)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every completed result handshake against the queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !sb_off) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got %0h expected none",
                 {class_onehot, class_id, class_hit, stable});
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        if ({class_onehot, class_id, class_hit, stable} !== e) begin
          n_err++;
          $display("FAIL result: got oh=%b id=%0d hit=%b st=%b expected oh=%b id=%0d hit=%b st=%b",
                   class_onehot, class_id, class_hit, stable, e[9:5], e[4:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic cfg(input logic [2:0] idx, input logic [23:0] lo, input logic [23:0] hi);
    cfg_idx = idx; cfg_lo = lo; cfg_hi = hi; cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [4:0] oh, input logic [2:0] id,
                      input logic hit, input logic st);
    bit acc;
    r_signal = r; g_signal = g; b_signal = b; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc) sb.push_back({oh, id, hit, st});
    else check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  localparam logic [23:0] NONE_LO = 24'hFFFFFF;
  localparam logic [23:0] NONE_HI = 24'h000000;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0;
    cfg_idx = '0; cfg_lo = '0; cfg_hi = '0;
    r_signal = '0; g_signal = '0; b_signal = '0;
`ifdef CLASSIFIER_HIST_EN
    hist_idx = '0; hist_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_hit_stable", {class_hit, stable, class_onehot}, 0);

    // Reset windows match nothing; result appears two cycles later.
    send(10, 20, 30, 5'b00000, 0, 0, 0);
    check("lat_cycle1_not_valid", out_valid, 0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", out_valid, 1);
    drain();

    // Overlapping windows: lowest index wins; then debounce to stable.
    cfg(0, 24'h000000, {8'd50, 8'd50, 8'd50});
    cfg(1, 24'h000000, 24'hFFFFFF);
    send(40, 40, 40, 5'b00011, 0, 1, 0);
    send(40, 40, 40, 5'b00011, 0, 1, 0);
    send(40, 40, 40, 5'b00011, 0, 1, 0);
    send(40, 40, 40, 5'b00011, 0, 1, 1);
    send(100, 100, 100, 5'b00010, 1, 1, 0);
    drain();

    // Back-pressure: A sits in S2, B in S1, pipe frozen for 3 cycles.
    out_ready = 1'b0;
    send(100, 100, 100, 5'b00010, 1, 1, 0);
    send(40, 40, 40, 5'b00011, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_frozen", {class_onehot, class_id}, {5'b00010, 3'd1});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Inclusive boundaries on class2 only.
    cfg(0, NONE_LO, NONE_HI);
    cfg(1, NONE_LO, NONE_HI);
    cfg(2, {8'd10, 8'd20, 8'd30}, {8'd60, 8'd70, 8'd80});
    send(10, 20, 30, 5'b00100, 2, 1, 0);
    send(60, 70, 80, 5'b00100, 2, 1, 0);
    send(9, 20, 30, 5'b00000, 0, 0, 0);
    send(10, 19, 30, 5'b00000, 0, 0, 0);
    send(10, 20, 29, 5'b00000, 0, 0, 0);
    send(61, 70, 80, 5'b00000, 0, 0, 0);
    send(60, 71, 80, 5'b00000, 0, 0, 0);
    send(60, 70, 81, 5'b00000, 0, 0, 0);
    send(10, 70, 30, 5'b00100, 2, 1, 0);
    drain();

    // Out-of-range index write is ignored.
    cfg(6, 24'h000000, 24'hFFFFFF);
    send(200, 200, 200, 5'b00000, 0, 0, 0);
    drain();

    // Write and accept in the same cycle: the sample sees the old window.
    cfg_idx = 3; cfg_lo = 24'h000000; cfg_hi = 24'hFFFFFF; cfg_we = 1'b1;
    r_signal = 200; g_signal = 200; b_signal = 200; in_valid = 1'b1;
    check("same_cycle_ready", in_ready, 1);
    sb.push_back({5'b00000, 3'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    send(200, 200, 200, 5'b01000, 3, 1, 0);
    send(200, 200, 200, 5'b01000, 3, 1, 0);
    send(200, 200, 200, 5'b01000, 3, 1, 0);
    send(200, 200, 200, 5'b01000, 3, 1, 1);
    send(200, 200, 200, 5'b01000, 3, 1, 1);
    drain();
    // A no-match result clears stable.
    cfg(3, NONE_LO, NONE_HI);
    send(200, 200, 200, 5'b00000, 0, 0, 0);
    drain();

    // Reset mid-stream drops the in-flight sample and the windows.
    cfg(0, 24'h000000, 24'hFFFFFF);
    r_signal = 1; g_signal = 1; b_signal = 1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 check("midrst_dropped", out_valid, 0);
    send(0, 0, 0, 5'b00000, 0, 0, 0);
    drain();

`ifdef CLASSIFIER_HIST_EN
    cfg(2, 24'h000000, 24'hFFFFFF);
    sb_off = 1'b1;
    r_signal = 5; g_signal = 5; b_signal = 5; in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 hist_idx = 3'd2;
    #1 check("hist_saturate", hist_count, 16'hFFFF);
    hist_clr = 1'b1;
    @(posedge clk); #1;
    hist_clr = 1'b0;
    check("hist_clear", hist_count, 16'h0000);
    sb_off = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
